// File: rtl/semaforo_pkg.sv
// Shared encodings and state type for the N-way traffic-light controller.
// Lamp codes are one-hot per approach; LUZ_APAGADA is only shown during night blink.
package semaforo_pkg;

    localparam logic [2:0] LUZ_VERDE    = 3'b001;
    localparam logic [2:0] LUZ_AMARELO  = 3'b010;
    localparam logic [2:0] LUZ_VERMELHO = 3'b100;
    localparam logic [2:0] LUZ_APAGADA  = 3'b000;

    typedef enum logic [1:0] {
        VERMELHO = 2'd0,
        VERDE    = 2'd1,
        AMARELO  = 2'd2
    } estado_t;

endpackage

// File: rtl/semaforo_req_latch.sv
// Request latch: rising-edge detect on level buttons plus sticky pending bits.
// Per bit, clr beats set; ign suppresses the set for the approach currently shown.
module semaforo_req_latch #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] bt,
    input  logic [N-1:0] ign,
    input  logic [N-1:0] clr,
    output logic [N-1:0] pend
);

    logic [N-1:0] bt_q;
    logic [N-1:0] pend_next;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            logic sobe;
            assign sobe          = bt[gi] & ~bt_q[gi];
            assign pend_next[gi] = clr[gi] ? 1'b0
                                 : (pend[gi] | (sobe & ~ign[gi]));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bt_q <= '0;
            pend <= '0;
        end else begin
            bt_q <= bt;
            pend <= pend_next;
        end
    end

endmodule

// File: rtl/semaforo_n.sv
// N-way traffic-light controller: one green at a time, round-robin with demand steering.
// Optional night blink mode is compiled in with SEMAFORO_NOTURNO_EN.
module semaforo_n
    import semaforo_pkg::*;
#(
    parameter int N_WAYS     = 2,
    parameter int CNT_W      = 8,
    parameter int T_VERDE    = 3,
    parameter int T_AMARELO  = 1,
    parameter int T_VERMELHO = 2,
    parameter int MIN_VERDE  = 1,
    parameter int T_PISCA    = 1,
    localparam int IDX_W     = $clog2(N_WAYS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_WAYS-1:0]     bt,
    output logic [3*N_WAYS-1:0]   luz,
    output logic [IDX_W-1:0]      idx,
    output logic [N_WAYS-1:0]     pend
`ifdef SEMAFORO_NOTURNO_EN
    ,
    input  logic                  noturno
`endif
);

    estado_t            estado;
    logic [CNT_W-1:0]   tempo;
    logic [N_WAYS-1:0]  dono_oh;
    logic [N_WAYS-1:0]  ign_mask;
    logic [N_WAYS-1:0]  clr_mask;
    logic [IDX_W-1:0]   prox;
    logic [IDX_W-1:0]   cand;
    logic               achou;
    logic               outro_pend;
    logic               min_ok;
    logic               entra_verde;
    logic               congelado;

    function automatic logic [3*N_WAYS-1:0] luz_uma(input logic [IDX_W-1:0] dono,
                                                    input logic [2:0]       cor);
        logic [3*N_WAYS-1:0] r;
        for (int i = 0; i < N_WAYS; i++)
            r[3*i +: 3] = (IDX_W'(i) == dono) ? cor : LUZ_VERMELHO;
        return r;
    endfunction

    function automatic logic [3*N_WAYS-1:0] luz_todas(input logic [2:0] cor);
        return {N_WAYS{cor}};
    endfunction

    generate
        for (genvar gi = 0; gi < N_WAYS; gi++) begin : g_dono
            assign dono_oh[gi] = (idx == IDX_W'(gi));
        end
    endgenerate

`ifdef SEMAFORO_NOTURNO_EN
    logic               noturno_q;
    logic               pisca_fase;
    logic [CNT_W-1:0]   pisca_cnt;
    // FSM stays frozen during blink and on the release edge that re-enters all-red
    assign congelado = noturno | noturno_q;
`else
    assign congelado = 1'b0;
`endif

    assign entra_verde = (estado == VERMELHO) && (tempo == CNT_W'(T_VERMELHO - 1)) && !congelado;
    assign ign_mask    = (estado != VERMELHO) ? dono_oh : '0;
    assign clr_mask    = entra_verde ? dono_oh : '0;
    assign outro_pend  = |(pend & ~dono_oh);
    assign min_ok      = ({1'b0, tempo} + (CNT_W + 1)'(1)) >= (CNT_W + 1)'(MIN_VERDE);

    // Round-robin search starting just after the current owner
    always_comb begin
        prox  = (idx == IDX_W'(N_WAYS - 1)) ? '0 : idx + IDX_W'(1);
        cand  = '0;
        achou = 1'b0;
        for (int k = 1; k < N_WAYS; k++) begin
            cand = IDX_W'((int'(idx) + k) % N_WAYS);
            if (!achou && pend[cand]) begin
                prox  = cand;
                achou = 1'b1;
            end
        end
    end

    semaforo_req_latch #(
        .N (N_WAYS)
    ) u_req (
        .clk  (clk),
        .rst  (rst),
        .bt   (bt),
        .ign  (ign_mask),
        .clr  (clr_mask),
        .pend (pend)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= VERMELHO;
            tempo  <= '0;
            idx    <= '0;
            luz    <= luz_todas(LUZ_VERMELHO);
`ifdef SEMAFORO_NOTURNO_EN
            noturno_q  <= 1'b0;
            pisca_fase <= 1'b0;
            pisca_cnt  <= '0;
`endif
        end else begin
`ifdef SEMAFORO_NOTURNO_EN
            noturno_q <= noturno;
            if (noturno) begin
                if (!noturno_q) begin
                    pisca_fase <= 1'b1;
                    pisca_cnt  <= '0;
                    luz        <= luz_todas(LUZ_AMARELO);
                end else if (pisca_cnt == CNT_W'(T_PISCA - 1)) begin
                    pisca_fase <= ~pisca_fase;
                    pisca_cnt  <= '0;
                    luz        <= luz_todas(pisca_fase ? LUZ_APAGADA : LUZ_AMARELO);
                end else begin
                    pisca_cnt  <= pisca_cnt + CNT_W'(1);
                end
            end else if (noturno_q) begin
                estado <= VERMELHO;
                tempo  <= '0;
                luz    <= luz_todas(LUZ_VERMELHO);
            end else
`endif
            begin
                case (estado)
                    VERMELHO: begin
                        if (tempo == CNT_W'(T_VERMELHO - 1)) begin
                            estado <= VERDE;
                            tempo  <= '0;
                            luz    <= luz_uma(idx, LUZ_VERDE);
                        end else begin
                            tempo  <= tempo + CNT_W'(1);
                        end
                    end
                    VERDE: begin
                        if ((tempo == CNT_W'(T_VERDE - 1)) || (min_ok && outro_pend)) begin
                            estado <= AMARELO;
                            tempo  <= '0;
                            luz    <= luz_uma(idx, LUZ_AMARELO);
                        end else begin
                            tempo  <= tempo + CNT_W'(1);
                        end
                    end
                    AMARELO: begin
                        if (tempo == CNT_W'(T_AMARELO - 1)) begin
                            estado <= VERMELHO;
                            tempo  <= '0;
                            idx    <= prox;
                            luz    <= luz_todas(LUZ_VERMELHO);
                        end else begin
                            tempo  <= tempo + CNT_W'(1);
                        end
                    end
                    default: begin
                        estado <= VERMELHO;
                        tempo  <= '0;
                        luz    <= luz_todas(LUZ_VERMELHO);
                    end
                endcase
            end
        end
    end

endmodule
